// File: rtl/dual_issue_if.sv
// Decode-to-scheduler bundle: two decoded slots, accepts back to decode,
// and the registered issue strobes toward the RF/forwarding stage.
interface dual_issue_if #(
    parameter int AW    = 7,
    parameter int LAT_W = 4
);
    logic             flush;
    logic             s0_valid;
    logic             s1_valid;
    logic             s0_pipe;
    logic             s1_pipe;
    logic             s0_reg_wr;
    logic             s1_reg_wr;
    logic [AW-1:0]    s0_reg_dst;
    logic [AW-1:0]    s1_reg_dst;
    logic [AW-1:0]    s0_ra;
    logic [AW-1:0]    s0_rb;
    logic [AW-1:0]    s0_rc;
    logic [AW-1:0]    s1_ra;
    logic [AW-1:0]    s1_rb;
    logic [AW-1:0]    s1_rc;
    logic [2:0]       s0_src_use;
    logic [2:0]       s1_src_use;
    logic [LAT_W-1:0] s0_latency;
    logic [LAT_W-1:0] s1_latency;
    logic             s0_accept;
    logic             s1_accept;
    logic             even_issue_valid;
    logic             odd_issue_valid;
    logic             even_issue_slot;
    logic             odd_issue_slot;
    logic             stall;

    modport master (
        output flush, s0_valid, s1_valid, s0_pipe, s1_pipe, s0_reg_wr, s1_reg_wr,
               s0_reg_dst, s1_reg_dst, s0_ra, s0_rb, s0_rc, s1_ra, s1_rb, s1_rc,
               s0_src_use, s1_src_use, s0_latency, s1_latency,
        input  s0_accept, s1_accept, even_issue_valid, odd_issue_valid,
               even_issue_slot, odd_issue_slot, stall
    );

    modport slave (
        input  flush, s0_valid, s1_valid, s0_pipe, s1_pipe, s0_reg_wr, s1_reg_wr,
               s0_reg_dst, s1_reg_dst, s0_ra, s0_rb, s0_rc, s1_ra, s1_rb, s1_rc,
               s0_src_use, s1_src_use, s0_latency, s1_latency,
        output s0_accept, s1_accept, even_issue_valid, odd_issue_valid,
               even_issue_slot, odd_issue_slot, stall
    );
endinterface

// File: rtl/dual_issue_scoreboard.sv
// In-order dual-issue scheduler with a per-register latency scoreboard.
// Optional ISSUE_PERF_CNT_EN adds saturating dual/single/stall counters.
module dual_issue_scoreboard #(
    parameter int NUM_REGS = 128,
    parameter int AW       = 7,
    parameter int LAT_W    = 4
) (
    input  logic        clk,
    input  logic        rst,
    dual_issue_if.slave bus
`ifdef ISSUE_PERF_CNT_EN
    ,
    output logic [31:0] perf_dual_cnt,
    output logic [31:0] perf_single_cnt,
    output logic [31:0] perf_stall_cnt
`endif
);

    localparam logic [LAT_W-1:0] CNT_ZERO = {LAT_W{1'b0}};
    localparam logic [LAT_W-1:0] CNT_ONE  = {{(LAT_W-1){1'b0}}, 1'b1};

    logic [LAT_W-1:0] cnt_r [NUM_REGS];

    logic ready0_s;
    logic ready1_s;
    logic dep_s;
    logic acc0_s;
    logic acc1_s;
    logic load0_s;
    logic load1_s;

    logic even_valid_r;
    logic odd_valid_r;
    logic even_slot_r;
    logic odd_slot_r;
    logic stall_r;

    // Slot readiness sees only registered counters; a pending load is invisible this cycle.
    function automatic logic slot_ready(
        input logic [2:0]       src_use,
        input logic [LAT_W-1:0] cnt_a,
        input logic [LAT_W-1:0] cnt_b,
        input logic [LAT_W-1:0] cnt_c,
        input logic             reg_wr,
        input logic [LAT_W-1:0] cnt_dst
    );
        return !(src_use[2] && (cnt_a != CNT_ZERO)) &&
               !(src_use[1] && (cnt_b != CNT_ZERO)) &&
               !(src_use[0] && (cnt_c != CNT_ZERO)) &&
               !(reg_wr && (cnt_dst != CNT_ZERO));
    endfunction

    // Readiness, intra-pair dependency and the combinational accepts.
    always_comb begin
        ready0_s = slot_ready(bus.s0_src_use, cnt_r[bus.s0_ra], cnt_r[bus.s0_rb],
                              cnt_r[bus.s0_rc], bus.s0_reg_wr, cnt_r[bus.s0_reg_dst]);
        ready1_s = slot_ready(bus.s1_src_use, cnt_r[bus.s1_ra], cnt_r[bus.s1_rb],
                              cnt_r[bus.s1_rc], bus.s1_reg_wr, cnt_r[bus.s1_reg_dst]);
        dep_s    = bus.s0_reg_wr &&
                   ((bus.s1_src_use[2] && (bus.s0_reg_dst == bus.s1_ra)) ||
                    (bus.s1_src_use[1] && (bus.s0_reg_dst == bus.s1_rb)) ||
                    (bus.s1_src_use[0] && (bus.s0_reg_dst == bus.s1_rc)) ||
                    (bus.s1_reg_wr     && (bus.s0_reg_dst == bus.s1_reg_dst)));
        acc0_s   = bus.s0_valid && ready0_s && !bus.flush;
        acc1_s   = acc0_s && bus.s1_valid && ready1_s &&
                   (bus.s1_pipe != bus.s0_pipe) && !dep_s && !bus.flush;
        load0_s  = acc0_s && bus.s0_reg_wr && (bus.s0_latency != CNT_ZERO);
        load1_s  = acc1_s && bus.s1_reg_wr && (bus.s1_latency != CNT_ZERO);
    end

    assign bus.s0_accept = acc0_s;
    assign bus.s1_accept = acc1_s;

    // Scoreboard counters: issue load beats the free-running decrement.
    always_ff @(posedge clk) begin
        for (int r = 0; r < NUM_REGS; r++) begin
            if (rst) begin
                cnt_r[r] <= CNT_ZERO;
            end else if (load0_s && (bus.s0_reg_dst == AW'(r))) begin
                cnt_r[r] <= bus.s0_latency;
            end else if (load1_s && (bus.s1_reg_dst == AW'(r))) begin
                cnt_r[r] <= bus.s1_latency;
            end else if (cnt_r[r] != CNT_ZERO) begin
                cnt_r[r] <= cnt_r[r] - CNT_ONE;
            end else begin
                cnt_r[r] <= cnt_r[r];
            end
        end
    end

    // Pipe routing and stall flag, one cycle after accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            even_valid_r <= 1'b0;
            odd_valid_r  <= 1'b0;
            even_slot_r  <= 1'b0;
            odd_slot_r   <= 1'b0;
            stall_r      <= 1'b0;
        end else begin
            // Accepted slots always target different pipes, so no pipe is claimed twice.
            even_valid_r <= (acc0_s && !bus.s0_pipe) || (acc1_s && !bus.s1_pipe);
            odd_valid_r  <= (acc0_s &&  bus.s0_pipe) || (acc1_s &&  bus.s1_pipe);
            even_slot_r  <= acc1_s && !bus.s1_pipe;
            odd_slot_r   <= acc1_s &&  bus.s1_pipe;
            stall_r      <= bus.s0_valid && !acc0_s;
        end
    end

    assign bus.even_issue_valid = even_valid_r;
    assign bus.odd_issue_valid  = odd_valid_r;
    assign bus.even_issue_slot  = even_slot_r;
    assign bus.odd_issue_slot   = odd_slot_r;
    assign bus.stall            = stall_r;

`ifdef ISSUE_PERF_CNT_EN
    // Saturating issue statistics.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_dual_cnt   <= 32'd0;
            perf_single_cnt <= 32'd0;
            perf_stall_cnt  <= 32'd0;
        end else begin
            if (acc1_s && (perf_dual_cnt != 32'hFFFF_FFFF)) begin
                perf_dual_cnt <= perf_dual_cnt + 32'd1;
            end else begin
                perf_dual_cnt <= perf_dual_cnt;
            end
            if (acc0_s && !acc1_s && (perf_single_cnt != 32'hFFFF_FFFF)) begin
                perf_single_cnt <= perf_single_cnt + 32'd1;
            end else begin
                perf_single_cnt <= perf_single_cnt;
            end
            if (bus.s0_valid && !acc0_s && (perf_stall_cnt != 32'hFFFF_FFFF)) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end else begin
                perf_stall_cnt <= perf_stall_cnt;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dual_issue_scoreboard.sv
// Scoreboard bench: a decode-queue driver with a ready-time reference model
// pushes expectations; a negedge monitor pops and compares.
module tb_dual_issue_scoreboard;

    typedef struct {
        logic       pipe;
        logic       wr;
        logic [6:0] dst;
        logic [6:0] ra;
        logic [6:0] rb;
        logic [6:0] rc;
        logic [2:0] use_m;
        logic [3:0] lat;
    } instr_t;

    typedef struct { logic a0; logic a1; } acc_t;
    typedef struct { logic ev; logic es; logic ov; logic os; logic st; } iss_t;

    logic clk;
    logic rst;

    dual_issue_if #(.AW(7), .LAT_W(4)) bus ();

`ifdef ISSUE_PERF_CNT_EN
    logic [31:0] perf_dual_cnt;
    logic [31:0] perf_single_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    dual_issue_scoreboard #(.NUM_REGS(128), .AW(7), .LAT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
`ifdef ISSUE_PERF_CNT_EN
        ,
        .perf_dual_cnt   (perf_dual_cnt),
        .perf_single_cnt (perf_single_cnt),
        .perf_stall_cnt  (perf_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int     checks = 0;
    int     errors = 0;
    int     cyc    = 0;
    int     ready_at [128];
    instr_t prog [$];
    acc_t   acc_q [$];
    iss_t   iss_q [$];

    // Reference model: a register is readable once the cycle count reaches its ready time.
    function automatic bit reg_ok(input logic [6:0] r);
        return cyc >= ready_at[r];
    endfunction

    function automatic bit ready(input instr_t i);
        return (!i.use_m[2] || reg_ok(i.ra)) && (!i.use_m[1] || reg_ok(i.rb)) &&
               (!i.use_m[0] || reg_ok(i.rc)) && (!i.wr || reg_ok(i.dst));
    endfunction

    function automatic instr_t mk(input logic pipe, input logic wr, input logic [6:0] dst,
                                  input logic [2:0] use_m, input logic [6:0] ra,
                                  input logic [6:0] rb, input logic [6:0] rc,
                                  input logic [3:0] lat);
        instr_t i;
        i.pipe = pipe; i.wr = wr; i.dst = dst; i.use_m = use_m;
        i.ra = ra; i.rb = rb; i.rc = rc; i.lat = lat;
        return i;
    endfunction

    function automatic logic [6:0] rnd_reg();
        logic [6:0] r;
        r = 7'($urandom_range(0, 11));
        if ($urandom_range(0, 7) == 0) r = r + 7'd116;
        return r;
    endfunction

    function automatic instr_t rnd_instr();
        return mk(1'($urandom), 1'($urandom), rnd_reg(), 3'($urandom_range(0, 7)),
                  rnd_reg(), rnd_reg(), rnd_reg(), 4'($urandom_range(0, 15)));
    endfunction

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %b expected %b", name, cyc, act, exp);
        end
    endtask

    // One scheduler cycle: present the two oldest pending instructions, predict, advance.
    task automatic step(input bit fl, input bit rs);
        instr_t i0, i1, idle;
        bit     v0, v1, a0, a1, dep;
        acc_t   ea;
        iss_t   ei;
        idle = mk(1'b0, 1'b0, 7'd0, 3'd0, 7'd0, 7'd0, 7'd0, 4'd0);
        v0 = !rs && (prog.size() > 0);
        v1 = !rs && (prog.size() > 1);
        i0 = v0 ? prog[0] : idle;
        i1 = v1 ? prog[1] : idle;
        rst = rs;
        bus.flush = fl;
        bus.s0_valid = v0; bus.s0_pipe = i0.pipe; bus.s0_reg_wr = i0.wr; bus.s0_reg_dst = i0.dst;
        bus.s0_ra = i0.ra; bus.s0_rb = i0.rb; bus.s0_rc = i0.rc;
        bus.s0_src_use = i0.use_m; bus.s0_latency = i0.lat;
        bus.s1_valid = v1; bus.s1_pipe = i1.pipe; bus.s1_reg_wr = i1.wr; bus.s1_reg_dst = i1.dst;
        bus.s1_ra = i1.ra; bus.s1_rb = i1.rb; bus.s1_rc = i1.rc;
        bus.s1_src_use = i1.use_m; bus.s1_latency = i1.lat;

        a0  = v0 && ready(i0) && !fl;
        dep = i0.wr && ((i1.use_m[2] && i0.dst == i1.ra) || (i1.use_m[1] && i0.dst == i1.rb) ||
                        (i1.use_m[0] && i0.dst == i1.rc) || (i1.wr && i0.dst == i1.dst));
        a1  = a0 && v1 && ready(i1) && (i1.pipe != i0.pipe) && !dep && !fl;
        ea.a0 = a0; ea.a1 = a1;
        ei.ev = (a0 && !i0.pipe) || (a1 && !i1.pipe);
        ei.ov = (a0 &&  i0.pipe) || (a1 &&  i1.pipe);
        ei.es = a1 && !i1.pipe;
        ei.os = a1 &&  i1.pipe;
        ei.st = v0 && !a0;
        acc_q.push_back(ea);
        iss_q.push_back(ei);

        @(posedge clk);
        #2;
        if (rs) begin
            foreach (ready_at[r]) ready_at[r] = 0;
        end else begin
            if (a0 && i0.wr && i0.lat != 4'd0) ready_at[i0.dst] = cyc + 1 + int'(i0.lat);
            if (a1 && i1.wr && i1.lat != 4'd0) ready_at[i1.dst] = cyc + 1 + int'(i1.lat);
        end
        if (a0) void'(prog.pop_front());
        if (a1) void'(prog.pop_front());
        cyc++;
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while (prog.size() > 0 && n < budget) begin
            step(1'b0, 1'b0);
            n++;
        end
        checks++;
        if (prog.size() != 0) begin
            errors++;
            $display("FAIL drain_%s: %0d instructions still pending after %0d cycles, required 0",
                     name, prog.size(), budget);
            prog.delete();
        end
    endtask

    // Monitor: pops the prediction for the current cycle and compares against the DUT.
    initial begin
        acc_t ea;
        iss_t ei;
        forever begin
            @(negedge clk);
            if (acc_q.size() > 0) begin
                ea = acc_q.pop_front();
                check("s0_accept", bus.s0_accept, ea.a0);
                check("s1_accept", bus.s1_accept, ea.a1);
                if (iss_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL issue_queue: got empty expectation queue, required one entry");
                end else begin
                    ei = iss_q.pop_front();
                    check("even_issue_valid", bus.even_issue_valid, ei.ev);
                    check("odd_issue_valid", bus.odd_issue_valid, ei.ov);
                    if (ei.ev) check("even_issue_slot", bus.even_issue_slot, ei.es);
                    if (ei.ov) check("odd_issue_slot", bus.odd_issue_slot, ei.os);
                    check("stall", bus.stall, ei.st);
                end
            end
        end
    end

    initial begin
        iss_t zero_iss;
        foreach (ready_at[r]) ready_at[r] = 0;
        rst = 1'b1;
        bus.flush = 1'b0; bus.s0_valid = 1'b0; bus.s1_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        zero_iss.ev = 1'b0; zero_iss.es = 1'b0; zero_iss.ov = 1'b0;
        zero_iss.os = 1'b0; zero_iss.st = 1'b0;
        iss_q.push_back(zero_iss);
        step(1'b0, 1'b1);

        // Independent pair, then a reader of r5 that must wait out latency 6.
        prog.push_back(mk(1'b0, 1'b1, 7'd5, 3'b000, 7'd0, 7'd0, 7'd0, 4'd6));
        prog.push_back(mk(1'b1, 1'b1, 7'd9, 3'b000, 7'd0, 7'd0, 7'd0, 4'd4));
        prog.push_back(mk(1'b0, 1'b0, 7'd0, 3'b100, 7'd5, 7'd0, 7'd0, 4'd0));
        drain("indep_then_raw", 30);

        // Intra-pair RAW on r3.
        prog.push_back(mk(1'b0, 1'b1, 7'd3, 3'b000, 7'd0, 7'd0, 7'd0, 4'd5));
        prog.push_back(mk(1'b1, 1'b0, 7'd0, 3'b010, 7'd0, 7'd3, 7'd0, 4'd0));
        drain("intra_raw", 30);

        // Same-dst pair and a structural (both even) pair.
        prog.push_back(mk(1'b0, 1'b1, 7'd20, 3'b000, 7'd0, 7'd0, 7'd0, 4'd2));
        prog.push_back(mk(1'b1, 1'b1, 7'd20, 3'b000, 7'd0, 7'd0, 7'd0, 4'd2));
        prog.push_back(mk(1'b0, 1'b0, 7'd0, 3'b000, 7'd0, 7'd0, 7'd0, 4'd0));
        prog.push_back(mk(1'b0, 1'b0, 7'd0, 3'b000, 7'd0, 7'd0, 7'd0, 4'd0));
        drain("waw_struct", 30);

        // Flush over a ready pair while r7 keeps counting down.
        prog.push_back(mk(1'b1, 1'b1, 7'd7, 3'b000, 7'd0, 7'd0, 7'd0, 4'd4));
        step(1'b0, 1'b0);
        prog.push_back(mk(1'b0, 1'b0, 7'd0, 3'b000, 7'd0, 7'd0, 7'd0, 4'd0));
        prog.push_back(mk(1'b1, 1'b0, 7'd0, 3'b000, 7'd0, 7'd0, 7'd0, 4'd0));
        prog.push_back(mk(1'b0, 1'b0, 7'd0, 3'b001, 7'd0, 7'd0, 7'd7, 4'd0));
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        drain("flush", 30);

        // Reset while r5 is busy; a reader of r5 goes straight through afterwards.
        prog.push_back(mk(1'b0, 1'b1, 7'd5, 3'b000, 7'd0, 7'd0, 7'd0, 4'd6));
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        prog.push_back(mk(1'b1, 1'b0, 7'd0, 3'b100, 7'd5, 7'd0, 7'd0, 4'd0));
        drain("reset_clear", 2);

        // Randomized traffic with occasional flush and reset.
        for (int n = 0; n < 2000; n++) begin
            while (prog.size() < 3) prog.push_back(rnd_instr());
            step($urandom_range(0, 9) == 0, $urandom_range(0, 149) == 0);
        end
        prog.delete();
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
